// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: scan FSM states and the per-channel threshold slicer.
package adc_scan_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_RDY, ACK, UPDATE, NEXT} state_t;

    // Returns the w-bit field k of a packed threshold vector (w <= 32).
    function automatic logic [31:0] thr(input logic [255:0] vec, input int k, input int w);
        return 32'(vec >> (k * w)) & ((32'd1 << w) - 32'd1);
    endfunction
endpackage

// File: rtl/hyst_cell.sv
// hyst_cell: one channel's threshold compare, confirm counter and level flag.
module hyst_cell #(
    parameter int                 DATA_W     = 12,
    parameter logic [DATA_W-1:0]  HIGH       = 1246,
    parameter logic [DATA_W-1:0]  LOW        = 1059,
    parameter int                 CONFIRM    = 2,
    parameter logic               LEVEL_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic [DATA_W-1:0] sample,
    output logic              level
);
    logic [3:0] cnt;
    logic       qual;
    logic       hit;

    assign qual = level ? (sample <= LOW) : (sample >= HIGH);
    assign hit  = (cnt + 4'd1) == 4'(CONFIRM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= LEVEL_INIT;
        end else if (upd) begin
            cnt <= (qual && !hit) ? cnt + 4'd1 : 4'd0;
            if (qual && hit) level <= ~level;
        end
    end
endmodule

// File: rtl/adc_scan_hysteresis.sv
// adc_scan_hysteresis: round-robin ADC scanner with 4-phase handshake and
// per-channel hysteresis/debounce level flags.
module adc_scan_hysteresis
    import adc_scan_pkg::*;
#(
    parameter int                        NUM_CH      = 4,
    parameter int                        DATA_W      = 12,
    parameter logic [NUM_CH*DATA_W-1:0]  X_HIGH      = {NUM_CH{DATA_W'(1246)}},
    parameter logic [NUM_CH*DATA_W-1:0]  X_LOW       = {NUM_CH{DATA_W'(1059)}},
    parameter int                        CONFIRM     = 2,
    parameter int                        TIMEOUT_CYC = 4096,
    parameter logic                      LEVEL_INIT  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     adc_ready,
    input  logic [DATA_W-1:0]        d_signal,
    output logic [2:0]               address,
    output logic                     adc_ack,
    output logic [NUM_CH-1:0]        level,
    output logic [NUM_CH*DATA_W-1:0] samples,
    output logic                     scan_done,
    output logic [NUM_CH-1:0]        timeout_err
);
    localparam int         TW   = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [2:0] LAST = 3'(NUM_CH - 1);

    state_t            state, next;
    logic [2:0]        ch;
    logic [TW-1:0]     tcnt;
    logic [DATA_W-1:0] work;
    logic              expired;

    assign expired = tcnt == TW'(TIMEOUT_CYC - 1);
    assign address = ch;

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = en ? WAIT_RDY : IDLE;
            WAIT_RDY: next = adc_ready ? ACK : (expired ? NEXT : WAIT_RDY);
            ACK:      next = adc_ready ? ACK : UPDATE;
            UPDATE:   next = NEXT;
            NEXT:     next = en ? WAIT_RDY : IDLE;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            tcnt        <= '0;
            work        <= '0;
            adc_ack     <= 1'b0;
            samples     <= '0;
            scan_done   <= 1'b0;
            timeout_err <= '0;
        end else begin
            state     <= next;
            // Ack follows the state register so it drops only after ready has been seen low.
            adc_ack   <= next == ACK;
            scan_done <= state == NEXT && ch == LAST;
            tcnt      <= state == WAIT_RDY ? tcnt + TW'(1) : '0;
            if (state == WAIT_RDY && adc_ready) work <= d_signal;
            if (state == NEXT) ch <= ch == LAST ? 3'd0 : ch + 3'd1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (state == WAIT_RDY && ch == 3'(k)) begin
                    if (adc_ready) samples[k*DATA_W +: DATA_W] <= d_signal;
                    else if (expired) timeout_err[k] <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cell
        hyst_cell #(
            .DATA_W    (DATA_W),
            .HIGH      (DATA_W'(thr(256'(X_HIGH), k, DATA_W))),
            .LOW       (DATA_W'(thr(256'(X_LOW), k, DATA_W))),
            .CONFIRM   (CONFIRM),
            .LEVEL_INIT(LEVEL_INIT)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .upd   (state == UPDATE && ch == 3'(k)),
            .sample(work),
            .level (level[k])
        );
    end
endmodule

// File: tb/tb_adc_scan_hysteresis.sv
// tb_adc_scan_hysteresis: directed checks of scan order, handshake, hysteresis,
// confirm debounce, timeout and asynchronous reset.
module tb_adc_scan_hysteresis;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        adc_ready = 1'b0;
    logic [11:0] d_signal = '0;
    logic [2:0]  address;
    logic        adc_ack;
    logic [3:0]  level;
    logic [47:0] samples;
    logic        scan_done;
    logic [3:0]  timeout_err;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    adc_scan_hysteresis #(.TIMEOUT_CYC(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .adc_ready  (adc_ready),
        .d_signal   (d_signal),
        .address    (address),
        .adc_ack    (adc_ack),
        .level      (level),
        .samples    (samples),
        .scan_done  (scan_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (scan_done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion: raise ready, wait for ack, hold ready, release, confirm ack drops next cycle.
    task automatic conv(input logic [11:0] v, input int hold, input logic [2:0] a);
        adc_ready = 1'b1;
        d_signal  = v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (adc_ack) break;
        end
        chk("ack_rise", adc_ack, 1);
        chk("addr", address, a);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("ack_hold", adc_ack, 1);
            chk("addr_hold", address, a);
        end
        adc_ready = 1'b0;
        @(negedge clk);
        chk("ack_fall", adc_ack, 0);
    endtask

    task automatic round(input logic [47:0] v, input logic [3:0] lv);
        for (int c = 0; c < 4; c++) conv(v[c*12 +: 12], 0, 3'(c));
        repeat (3) @(negedge clk);
        chk("level", level, lv);
        chk("samples", samples, v);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_addr", address, 0);
        chk("rst_ack", adc_ack, 0);
        chk("rst_level", level, 0);
        chk("rst_samples", samples, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_tmo", timeout_err, 0);
        rst = 1'b0;
        en  = 1'b1;

        round({4{12'd2000}}, 4'b0000);
        chk("done_r1", done_cnt, 1);
        round({4{12'd2000}}, 4'b1111);
        chk("done_r2", done_cnt, 2);

        conv(12'd1500, 10, 3'd0);
        conv(12'd2000, 0, 3'd1);
        conv(12'd2000, 0, 3'd2);
        for (int i = 0; i < 20; i++) begin
            if (address == 3'd3) break;
            @(negedge clk);
        end
        chk("tmo_addr", address, 3);
        repeat (63) @(negedge clk);
        chk("tmo_early", timeout_err, 4'b0000);
        @(negedge clk);
        chk("tmo_set", timeout_err, 4'b1000);
        chk("tmo_level", level, 4'b1111);
        chk("tmo_sample", samples[47:36], 2000);
        @(negedge clk);
        chk("tmo_done", scan_done, 1);
        chk("tmo_next", address, 0);

        en = 1'b0;
        conv(12'd2000, 0, 3'd0);
        repeat (10) @(negedge clk);
        chk("idle_addr", address, 1);
        chk("idle_ack", adc_ack, 0);
        chk("tmo_sticky", timeout_err, 4'b1000);

        en = 1'b1;
        adc_ready = 1'b1;
        d_signal  = 12'd123;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (adc_ack) break;
        end
        chk("mid_ack", adc_ack, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ack", adc_ack, 0);
        chk("arst_addr", address, 0);
        chk("arst_level", level, 0);
        chk("arst_samples", samples, 0);
        chk("arst_tmo", timeout_err, 0);
        @(negedge clk);
        adc_ready = 1'b0;
        rst = 1'b0;

        round({12'd0, 12'd1250, 12'd1300, 12'd0}, 4'b0000);
        round({12'd0, 12'd1200, 12'd1300, 12'd0}, 4'b0010);
        round({12'd0, 12'd1250, 12'd1100, 12'd0}, 4'b0010);
        round({12'd0, 12'd1250, 12'd1100, 12'd0}, 4'b0110);
        round({12'd0, 12'd2000, 12'd1100, 12'd0}, 4'b0110);
        round({12'd0, 12'd2000, 12'd1059, 12'd0}, 4'b0110);
        round({12'd0, 12'd2000, 12'd1059, 12'd0}, 4'b0100);
        round({12'd0, 12'd2000, 12'd1300, 12'd0}, 4'b0100);
        round({12'd0, 12'd2000, 12'd1300, 12'd0}, 4'b0110);
        round({12'd0, 12'd2000, 12'd1059, 12'd0}, 4'b0110);
        round({12'd0, 12'd2000, 12'd1100, 12'd1246}, 4'b0110);
        round({12'd0, 12'd2000, 12'd1059, 12'd1246}, 4'b0111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_scan_hysteresis.md
Name: adc_scan_hysteresis

Overview:
Multi-channel successor to the single-channel ADC hysteresis stage. It sequences the SPI ADC capture block round-robin over NUM_CH input channels and runs the 4-phase ready/ack handshake per conversion. Each channel gets its own high/low thresholds and a confirm-count debounce. Outputs are per-channel level flags plus the latest samples, consumed by the drive/steering control logic (e.g. obstacle sensing in several directions).

Parameters:
NUM_CH, 4, number of scanned channels, 1..8; channel k uses ADC address k.
DATA_W, 12, ADC sample width.
X_HIGH, {4{12'd1246}}, packed NUM_CH*DATA_W upper thresholds; channel k in bits [k*DATA_W +: DATA_W].
X_LOW, {4{12'd1059}}, packed NUM_CH*DATA_W lower thresholds; X_LOW[k] < X_HIGH[k] required.
CONFIRM, 2, consecutive qualifying samples needed to flip a level, 1..15.
TIMEOUT_CYC, 4096, clk cycles to wait for adc_ready before abandoning a conversion.
LEVEL_INIT, 1'b0, reset value of every level bit.

Ports:
clk  in  1  system clock (25 MHz)
rst  in  1  asynchronous active-high reset
en  in  1  scan enable; 0 = finish current channel, then idle
adc_ready  in  1  capture block has a valid sample
d_signal  in  DATA_W  sample from the capture block, valid while adc_ready=1
address  out  3  ADC channel select to the capture block
adc_ack  out  1  sample-consumed acknowledge to the capture block
level  out  NUM_CH  hysteresis flag per channel (1 = above band)
samples  out  NUM_CH*DATA_W  last accepted sample per channel
scan_done  out  1  one-cycle pulse after channel NUM_CH-1 completes
timeout_err  out  NUM_CH  sticky per-channel timeout flag

Behaviour:
- Reset (async): FSM=IDLE, ch=0, address=0, adc_ack=0, level={NUM_CH{LEVEL_INIT}}, samples=0, confirm counters=0, scan_done=0, timeout_err=0.
- FSM states: IDLE, WAIT_RDY, ACK, UPDATE, NEXT.
- IDLE: address=ch. If en=1 -> WAIT_RDY, timeout counter cleared.
- WAIT_RDY: address held stable. adc_ready=1 -> latch d_signal into samples[ch] and working register; go to ACK. If the counter reaches TIMEOUT_CYC-1 with no ready -> set timeout_err[ch]; level, samples and counters unchanged; go to NEXT.
- ACK: adc_ack=1, registered; held until adc_ready samples 0, then adc_ack=0 next cycle -> UPDATE. Never drop ack while ready is high (4-phase).
- UPDATE (one cycle), for channel ch with sample s:
  - level=0: s >= X_HIGH[ch] increments cnt[ch], any other s clears it; cnt reaching CONFIRM -> level=1, cnt=0.
  - level=1: s <= X_LOW[ch] increments cnt[ch], any other s clears it; cnt reaching CONFIRM -> level=0, cnt=0.
  - Comparisons unsigned, DATA_W bits. A sample equal to a threshold qualifies.
  - Then -> NEXT.
- NEXT: ch = (ch==NUM_CH-1) ? 0 : ch+1. scan_done pulses when wrapping from NUM_CH-1, including after a timeout. Then -> WAIT_RDY if en=1, else IDLE.
- en falling mid-conversion: the current handshake completes; the FSM stops in IDLE at the following channel.
- Latency: level changes visible 2 cycles after adc_ready falls (ACK release + UPDATE).
- timeout_err clears only on reset.
- NUM_CH=1: ch stays 0, and scan_done pulses every conversion.

Decomposition:
- Package adc_scan_pkg: state enum, helper function thr(vec,k) for slicing a packed threshold.
- One sub-module, hyst_cell: per-channel compare + confirm counter + level register, with an update strobe and a sample input. It is generated NUM_CH times, and only the cell for the selected channel is strobed.

Test Plan:
- Basic scan, NUM_CH=4: model returns 2000 on every channel; expect address sequence 0,1,2,3,0. With CONFIRM=2, every level goes 1 after the second round, and scan_done pulses once per round.
- Hysteresis band: channel 1 gets 1300,1300 (level 1), then 1100 ×3 (stays 1), then 1059,1059 (level 0). Single 1059 followed by 1100 leaves level=1.
- Confirm reset: channel 2 gets 1250, 1200, 1250 -> level stays 0. Another 1250 makes level=1.
- Handshake: model holds adc_ready high 10 cycles after ack. adc_ack stays 1 for all 10 cycles, drops the cycle after ready falls, and address is stable throughout WAIT_RDY/ACK.
- Timeout: channel 3 never asserts ready, TIMEOUT_CYC=64. Expect timeout_err[3]=1 after 64 cycles, level[3] unchanged, scan continues at channel 0, scan_done still pulses.
- Reset mid-ACK: assert rst while adc_ack=1. Outputs return to reset values asynchronously, and after release the scan restarts at address 0.
